// File: rtl/tt_um_verilog_meetup_bist.sv
// Loopback BIST for the uio lanes: drives an LFSR or walking-one pattern, compares it with the sampled loopback and reports pass/fail.
// Optional macro BIST_FIRST_FAIL_EN adds capture and display of the first failing cycle index.
module tt_um_verilog_meetup_bist #(
  parameter int          WIDTH = 8,
  parameter int          LEN_W = 8,
  parameter logic [7:0]  SEED  = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LANE_MASK = 8'((9'd1 << WIDTH) - 9'd1);

  state_t             state_q, state_d;
  logic               start_prev_q;
  logic               mode_q, mode_d;
  logic [7:0]         pat_q, pat_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         err_q, err_d;

  logic               start_edge;
  logic               start_ok;
  logic               run_active;
  logic               last_cycle;
  logic               err_hit;
  logic [7:0]         lfsr_next;
  logic [7:0]         walk_next;
  logic               busy, done, pass, fail;
  logic [7:0]         status;

  assign start_edge = ui_in[0] & ~start_prev_q;
  assign start_ok   = ena & start_edge & (state_q != RUN);
  assign run_active = ena & (state_q == RUN);
  assign last_cycle = (cnt_q == '1);
  assign err_hit    = (uio_in[WIDTH-1:0] != pat_q[WIDTH-1:0]) | ui_in[2];

  // Galois LFSR, right shift, taps 8'hB8
  assign lfsr_next = (pat_q >> 1) ^ (pat_q[0] ? 8'hB8 : 8'h00);

  always_comb begin
    walk_next    = '0;
    walk_next[0] = pat_q[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      walk_next[i] = pat_q[i-1];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_edge) state_d = RUN;
        RUN:     if (last_cycle) state_d = DONE;
        DONE:    if (start_edge) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (start_ok) begin
      mode_d = ui_in[1];
      pat_d  = ui_in[1] ? 8'h01 : SEED;
      cnt_d  = '0;
      err_d  = '0;
    end else if (run_active) begin
      pat_d = mode_q ? walk_next : lfsr_next;
      cnt_d = cnt_q + 1'b1;
      if (err_hit && (err_q != 4'hF)) begin
        err_d = err_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q <= 1'b0;
      mode_q       <= 1'b0;
      pat_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
    end else begin
      start_prev_q <= ui_in[0];
      mode_q       <= mode_d;
      pat_q        <= pat_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Output decode
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    pass   = done & (err_q == 4'd0);
    fail   = done & (err_q != 4'd0);
    status = {err_q, fail, pass, done, busy};
  end

`ifdef BIST_FIRST_FAIL_EN
  logic [7:0] ff_q, ff_d;

  // Error count still zero means this is the first error of the run
  always_comb begin
    ff_d = ff_q;
    if (start_ok) begin
      ff_d = '0;
    end else if (run_active && err_hit && (err_q == 4'd0)) begin
      ff_d = 8'(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign uo_out = (fail && ui_in[3]) ? ff_q : status;

  logic unused_bits;
  assign unused_bits = &{1'b0, ui_in[7:4], uio_in};
`else
  assign uo_out = status;

  logic unused_bits;
  assign unused_bits = &{1'b0, ui_in[7:3], uio_in};
`endif

  assign uio_out = pat_q & LANE_MASK;
  assign uio_oe  = busy ? LANE_MASK : 8'h00;

endmodule

// File: tb/tb_tt_um_verilog_meetup_bist.sv
// Directed self-checking bench: 8-lane and 4-lane instances share clock, reset, ena and ui_in.
module tb_tt_um_verilog_meetup_bist;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] stuck_mask;

  logic [7:0] uo8, uio_out8, uio_oe8, uio_in8;
  logic [7:0] uo4, uio_out4, uio_oe4, uio_in4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] lfsr_tab [16] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8,
                                8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE, 8'h57};
  logic [7:0] exp_v;

`ifdef BIST_FIRST_FAIL_EN
  localparam logic [7:0] FF_SHOW = 8'h02;
`else
  localparam logic [7:0] FF_SHOW = 8'h2A;
`endif

  assign uio_in8 = uio_out8 & stuck_mask;
  assign uio_in4 = uio_out4;

  tt_um_verilog_meetup_bist #(.WIDTH(8), .LEN_W(4), .SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo8),
    .uio_in(uio_in8), .uio_out(uio_out8), .uio_oe(uio_oe8)
  );

  tt_um_verilog_meetup_bist #(.WIDTH(4), .LEN_W(4), .SEED(8'h01)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo4),
    .uio_in(uio_in4), .uio_out(uio_out4), .uio_oe(uio_oe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    ui_in      = 8'h00;
    stuck_mask = 8'hFF;
    #2;
    check("rst_uo", uo8, 8'h00);
    check("rst_uio_out", uio_out8, 8'h00);
    check("rst_uio_oe", uio_oe8, 8'h00);
    check("rst_uo4", uo4, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_uo", uo8, 8'h00);

    // LFSR run with clean loopback; start held high the whole time
    ui_in = 8'h01;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("lfsr_pat", uio_out8, lfsr_tab[i]);
      check("lfsr_busy", uo8, 8'h01);
      check("lfsr_oe", uio_oe8, 8'hFF);
    end
    @(negedge clk);
    check("lfsr_done", uo8, 8'h06);
    check("lfsr_done_oe", uio_oe8, 8'h00);
    repeat (3) @(negedge clk);
    check("start_held_no_retrig", uo8, 8'h06);

    // Inject on every cycle: count saturates at 15
    ui_in = 8'h00;
    @(negedge clk);
    ui_in = 8'h05;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_v = {4'(i), 4'h1};
      check("inj_busy", uo8, exp_v);
    end
    @(negedge clk);
    check("inj_done_sat", uo8, 8'hFA);

    // Walking-one, bit 2 stuck low on the 8-lane instance
    ui_in      = 8'h00;
    stuck_mask = 8'hFB;
    @(negedge clk);
    check("w4_oe_done", uio_oe4, 8'h00);
    ui_in = 8'h03;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_v = 8'h01 << (i % 8);
      check("walk8_pat", uio_out8, exp_v);
      exp_v = 8'h01 << (i % 4);
      check("walk4_pat", uio_out4, exp_v);
      check("walk4_oe", uio_oe4, 8'h0F);
    end
    @(negedge clk);
    check("stuck_done", uo8, 8'h2A);
    check("walk4_oe_done", uio_oe4, 8'h00);
    check("walk4_pass", uo4, 8'h06);
    ui_in = 8'h0B;
    #1;
    check("first_fail_show", uo8, FF_SHOW);
    check("first_fail_pass4", uo4, 8'h06);
    ui_in = 8'h03;
    #1;
    check("first_fail_off", uo8, 8'h2A);

    // ena low mid-run: status cleared, error count kept, start ignored
    stuck_mask = 8'hFF;
    ui_in = 8'h00;
    @(negedge clk);
    ui_in = 8'h05;
    repeat (3) @(negedge clk);
    check("ena_pre", uo8, 8'h21);
    ena = 1'b0;
    @(negedge clk);
    check("ena_low_uo", uo8, 8'h20);
    check("ena_low_oe", uio_oe8, 8'h00);
    ui_in = 8'h00;
    @(negedge clk);
    ui_in = 8'h01;
    repeat (2) @(negedge clk);
    check("ena_low_start", uo8, 8'h20);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    check("ena_up_no_edge", uo8, 8'h20);

    // Reset in RUN cycle 5
    ui_in = 8'h00;
    @(negedge clk);
    ui_in = 8'h01;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", uo8, 8'h01);
    check("pre_rst_pat", uio_out8, lfsr_tab[4]);
    rst_n = 1'b0;
    ui_in = 8'h00;
    #1;
    check("midrst_uo", uo8, 8'h00);
    check("midrst_uio_out", uio_out8, 8'h00);
    check("midrst_uio_oe", uio_oe8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_uo", uo8, 8'h00);
    check("post_rst_oe", uio_oe8, 8'h00);
    ui_in = 8'h01;
    @(negedge clk);
    check("restart_busy", uo8, 8'h01);
    check("restart_pat", uio_out8, 8'h01);
    repeat (16) @(negedge clk);
    check("restart_done", uo8, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
